// File: rtl/min_sec_time_base.sv
// Seconds/minutes time base: prescaled one-second tick feeding chained
// base-60 seconds and minutes fields, with set-mode adjust and hour pulses.
module min_sec_time_base #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int PRESC_W       = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_run,
    input  logic       i_sel,
    input  logic       i_adj_up,
    input  logic       i_adj_down,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic       o_tick,
    output logic       o_hour_up,
    output logic       o_hour_down
);

    localparam logic [PRESC_W-1:0] PMAX = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [5:0]         sec_q, sec_d;
    logic [5:0]         min_q, min_d;
    logic               tick_q, tick_d;
    logic               hup_q, hup_d;
    logic               hdn_q, hdn_d;

    logic adj_up, adj_dn, adj_clr;
    logic sec_up, sec_dn, sec_clr;
    logic min_up, min_dn, min_clr;
    logic sec_cy, sec_bw;

    // Event decode, prescaler and the seconds -> minutes -> hour chain.
    always_comb begin
        presc_d = '0;
        tick_d  = 1'b0;
        sec_d   = sec_q;
        min_d   = min_q;
        hup_d   = 1'b0;
        hdn_d   = 1'b0;
        sec_cy  = 1'b0;
        sec_bw  = 1'b0;
        sec_up  = 1'b0;
        sec_dn  = 1'b0;
        sec_clr = 1'b0;
        min_up  = 1'b0;
        min_dn  = 1'b0;
        min_clr = 1'b0;

        adj_up  = i_adj_up & ~i_adj_down;
        adj_dn  = i_adj_down & ~i_adj_up;
        adj_clr = i_adj_up & i_adj_down;

        if (i_run) begin
            if (presc_q == PMAX) begin
                tick_d = 1'b1;
                sec_up = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (i_sel) begin
            min_up  = adj_up;
            min_dn  = adj_dn;
            min_clr = adj_clr;
        end else begin
            sec_up  = adj_up;
            sec_dn  = adj_dn;
            sec_clr = adj_clr;
        end

        if (sec_clr) begin
            sec_d = '0;
        end else if (sec_up) begin
            if (sec_q == 6'd59) begin
                sec_d  = '0;
                sec_cy = 1'b1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (sec_dn) begin
            if (sec_q == 6'd0) begin
                sec_d  = 6'd59;
                sec_bw = 1'b1;
            end else begin
                sec_d = sec_q - 6'd1;
            end
        end

        if (min_clr) begin
            min_d = '0;
        end else if (min_up | sec_cy) begin
            if (min_q == 6'd59) begin
                min_d = '0;
                hup_d = 1'b1;
            end else begin
                min_d = min_q + 6'd1;
            end
        end else if (min_dn | sec_bw) begin
            if (min_q == 6'd0) begin
                min_d = 6'd59;
                hdn_d = 1'b1;
            end else begin
                min_d = min_q - 6'd1;
            end
        end
    end

    // State and output registers; reset clears everything including pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            tick_q  <= 1'b0;
            hup_q   <= 1'b0;
            hdn_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            tick_q  <= tick_d;
            hup_q   <= hup_d;
            hdn_q   <= hdn_d;
        end
    end

    assign o_sec       = sec_q;
    assign o_min       = min_q;
    assign o_tick      = tick_q;
    assign o_hour_up   = hup_q;
    assign o_hour_down = hdn_q;

endmodule
